// File: rtl/cla_addsub_pkg.sv
// Shared definitions for the pipelined CLA adder/subtractor: operation
// encodings, flag bit positions and the operation decode helpers.
package cla_addsub_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ADC = 2'b10;
  localparam logic [1:0] OP_SBC = 2'b11;

  localparam int FLAG_C = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

  // SUB and SBC add the one's complement of B.
  function automatic logic op_inv_b(input logic [1:0] op);
    return (op == OP_SUB) || (op == OP_SBC);
  endfunction

  // Carry into bit 0; for SBC a set cin means "no borrow".
  function automatic logic op_c0(input logic [1:0] op, input logic cin);
    logic c0;
    case (op)
      OP_ADD:  c0 = 1'b0;
      OP_SUB:  c0 = 1'b1;
      default: c0 = cin;
    endcase
    return c0;
  endfunction

endpackage

// File: rtl/cla_addsub_pipe_if.sv
// Valid/ready operand and result bus of cla_addsub_pipe.
// The sat signal exists only when CLA_ADDSUB_SAT_EN is defined.
interface cla_addsub_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             cin;
`ifdef CLA_ADDSUB_SAT_EN
  logic             sat;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             flag_c;
  logic             flag_v;
  logic             flag_z;
  logic             flag_n;

  // Producer of operands / consumer of results.
  modport master (
    output in_valid, a, b, op, cin,
`ifdef CLA_ADDSUB_SAT_EN
    output sat,
`endif
    output out_ready,
    input  in_ready, out_valid, sum, flag_c, flag_v, flag_z, flag_n
  );

  // The arithmetic core.
  modport slave (
    input  in_valid, a, b, op, cin,
`ifdef CLA_ADDSUB_SAT_EN
    input  sat,
`endif
    input  out_ready,
    output in_ready, out_valid, sum, flag_c, flag_v, flag_z, flag_n
  );

endinterface

// File: rtl/cla_group4.sv
// 4-bit carry-lookahead group: sum bits, carry out of bit 3 and the carry
// into bit 3 (needed for signed overflow when this is the MSB group).
module cla_group4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co,
  output logic       c3
);
  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;

  assign g = a & b;
  assign p = a ^ b;

  // Flat lookahead equations; no carry ripples inside the group.
  assign c1 = g[0] | (p[0] & ci);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s = p ^ {c3, c2, c1, ci};

endmodule

// File: rtl/cla_addsub_pipe.sv
// Pipelined N-bit adder/subtractor built from 4-bit CLA groups.
// Each stage evaluates GROUPS_PER_STAGE groups; the inter-group carry,
// the not-yet-used operand bits (skew) and the finished sum bits (deskew)
// are registered between stages. The last stage's register is the output
// register, so latency is LAT = WIDTH/(4*GROUPS_PER_STAGE) cycles.
// Optional feature: define CLA_ADDSUB_SAT_EN to add saturating mode.
// WIDTH must be a multiple of 4; GROUPS_PER_STAGE must divide WIDTH/4.
module cla_addsub_pipe
  import cla_addsub_pkg::*;
#(
  parameter int WIDTH            = 16,
  parameter int GROUPS_PER_STAGE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  cla_addsub_pipe_if.slave bus
);

  localparam int SW  = 4 * GROUPS_PER_STAGE;  // bits handled per stage
  localparam int LAT = WIDTH / SW;

  logic             advance;
  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic [3:0]       flags_q;

  // Signals leaving the last stage's combinational logic.
  logic [WIDTH-1:0] fin_s;
  logic             fin_c;
  logic             fin_c3;
  logic             fin_valid;
`ifdef CLA_ADDSUB_SAT_EN
  logic             fin_sat;
  logic             fin_a_msb;
`endif
  logic [WIDTH-1:0] fin_sum;
  logic             fin_v;

  // The whole pipeline moves as one; a stalled output freezes every stage.
  assign advance      = !out_valid_q || bus.out_ready;
  assign bus.in_ready = advance;

  for (genvar k = 0; k < LAT; k++) begin : g_stage
    localparam int OPW  = WIDTH - k * SW;  // operand bits still to process
    localparam int DONE = (k + 1) * SW;    // sum bits finished after this stage

    logic [OPW-1:0]            a_in;
    logic [OPW-1:0]            b_in;
    logic                      c_in;
    logic                      v_in;
`ifdef CLA_ADDSUB_SAT_EN
    logic                      sat_in;
`endif
    logic [GROUPS_PER_STAGE:0]   c;
    logic [GROUPS_PER_STAGE-1:0] c3;
    logic [SW-1:0]             grp_s;
    logic [DONE-1:0]           s_nx;

    if (k == 0) begin : g_src
      assign a_in = bus.a;
      assign b_in = bus.b ^ {WIDTH{op_inv_b(bus.op)}};
      assign c_in = op_c0(bus.op, bus.cin);
      assign v_in = bus.in_valid;
`ifdef CLA_ADDSUB_SAT_EN
      assign sat_in = bus.sat;
`endif
      assign s_nx = grp_s;
    end else begin : g_src
      assign a_in = g_stage[k-1].g_reg.a_q;
      assign b_in = g_stage[k-1].g_reg.b_q;
      assign c_in = g_stage[k-1].g_reg.c_q;
      assign v_in = g_stage[k-1].g_reg.v_q;
`ifdef CLA_ADDSUB_SAT_EN
      assign sat_in = g_stage[k-1].g_reg.sat_q;
`endif
      assign s_nx = {grp_s, g_stage[k-1].g_reg.s_q};
    end

    // Groups inside a stage chain their carries combinationally.
    assign c[0] = c_in;
    for (genvar j = 0; j < GROUPS_PER_STAGE; j++) begin : g_grp
      cla_group4 u_grp (
        .a  (a_in[4*j +: 4]),
        .b  (b_in[4*j +: 4]),
        .ci (c[j]),
        .s  (grp_s[4*j +: 4]),
        .co (c[j+1]),
        .c3 (c3[j])
      );
    end

    if (k < LAT - 1) begin : g_reg
      logic [OPW-SW-1:0] a_q;
      logic [OPW-SW-1:0] b_q;
      logic [DONE-1:0]   s_q;
      logic              c_q;
      logic              v_q;
`ifdef CLA_ADDSUB_SAT_EN
      logic              sat_q;
`endif

      // Stage register: carry, skewed operands, deskewed sum and valid move together.
      // NOTE: sequential state uses non-blocking assignments so every stage samples its predecessor's pre-edge value.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          // NOTE: data fields are reset as well so outputs never carry X after reset.
          v_q <= 1'b0;
          c_q <= 1'b0;
          a_q <= '0;
          b_q <= '0;
          s_q <= '0;
`ifdef CLA_ADDSUB_SAT_EN
          sat_q <= 1'b0;
`endif
        end else if (advance) begin
          v_q <= v_in;
          c_q <= c[GROUPS_PER_STAGE];
          a_q <= a_in[OPW-1:SW];
          b_q <= b_in[OPW-1:SW];
          s_q <= s_nx;
`ifdef CLA_ADDSUB_SAT_EN
          sat_q <= sat_in;
`endif
        end
      end
    end else begin : g_fin
      assign fin_s     = s_nx;
      assign fin_c     = c[GROUPS_PER_STAGE];
      assign fin_c3    = c3[GROUPS_PER_STAGE-1];
      assign fin_valid = v_in;
`ifdef CLA_ADDSUB_SAT_EN
      assign fin_sat   = sat_in;
      assign fin_a_msb = a_in[SW-1];
`endif
    end
  end

  assign fin_v = fin_c3 ^ fin_c;

  // Final result, clamped on signed overflow when saturation is requested.
  always_comb begin
    // NOTE: default assignment first keeps this block free of latches.
    fin_sum = fin_s;
`ifdef CLA_ADDSUB_SAT_EN
    if (fin_sat && fin_v) begin
      // On overflow both addends share A's sign, so A's MSB gives the direction.
      fin_sum = fin_a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // Output register; result and flags only update when a valid op lands,
  // so they keep their last value across bubbles and stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      flags_q     <= '0;
    end else if (advance) begin
      out_valid_q <= fin_valid;
      if (fin_valid) begin
        sum_q           <= fin_sum;
        flags_q[FLAG_C] <= fin_c;
        flags_q[FLAG_V] <= fin_v;
        flags_q[FLAG_Z] <= ~|fin_sum;
        flags_q[FLAG_N] <= fin_sum[WIDTH-1];
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.flag_c    = flags_q[FLAG_C];
  assign bus.flag_v    = flags_q[FLAG_V];
  assign bus.flag_z    = flags_q[FLAG_Z];
  assign bus.flag_n    = flags_q[FLAG_N];

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Self-checking bench for cla_addsub_pipe (WIDTH=16, one group per stage).
// Reference model uses plain integer arithmetic on the operation rules.
module tb_cla_addsub_pipe;
  import cla_addsub_pkg::*;

  localparam int W   = 16;
  localparam int GPS = 1;
  localparam int LAT = W / (4 * GPS);

  typedef struct packed {
    logic [W-1:0] sum;
    logic         c;
    logic         v;
    logic         z;
    logic         n;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  cla_addsub_pipe_if #(.WIDTH(W)) bus ();

  cla_addsub_pipe #(.WIDTH(W), .GROUPS_PER_STAGE(GPS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [1:0] op, input logic cin, input logic sat);
    logic [W-1:0] bb;
    logic         c0;
    logic [W:0]   full;
    res_t         r;
    bb   = (op == OP_SUB || op == OP_SBC) ? ~b : b;
    c0   = (op == OP_ADD) ? 1'b0 : (op == OP_SUB) ? 1'b1 : cin;
    full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c0};
    r.sum = full[W-1:0];
    r.c   = full[W];
    r.v   = (a[W-1] == bb[W-1]) && (r.sum[W-1] != a[W-1]);
    if (sat && r.v) r.sum = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    r.z = (r.sum == '0);
    r.n = r.sum[W-1];
    return r;
  endfunction

  function automatic res_t observed();
    return {bus.sum, bus.flag_c, bus.flag_v, bus.flag_z, bus.flag_n};
  endfunction

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] op, input logic cin, input logic sat, input logic ordy);
    bus.in_valid  = v;
    bus.a         = a;
    bus.b         = b;
    bus.op        = op;
    bus.cin       = cin;
`ifdef CLA_ADDSUB_SAT_EN
    bus.sat       = sat;
`else
    if (sat) bus.cin = cin;  // sat has no effect in the wrapping build
`endif
    bus.out_ready = ordy;
  endtask

  // One op into an empty pipeline; checks latency, sum and {C,V,Z,N}.
  task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [1:0] op, input logic cin, input logic sat,
                          input logic [W-1:0] exp_sum, input logic [3:0] exp_cvzn);
    int cnt;
    @(negedge clk);
    drive(1'b1, a, b, op, cin, sat, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    cnt = 1;
    while (!bus.out_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check({tag, "_lat"}, cnt, LAT);
    check({tag, "_sum"}, bus.sum, exp_sum);
    check({tag, "_cvzn"}, {bus.flag_c, bus.flag_v, bus.flag_z, bus.flag_n}, exp_cvzn);
  endtask

  // Streamed ops against a scoreboard queue. stall_mode: continuous input,
  // out_ready low in cycles 5..7; otherwise random valid/ready.
  task automatic stream(input int n_ops, input bit stall_mode);
    res_t         exp_q[$];
    res_t         prev;
    logic         prev_hold;
    logic [W-1:0] ca, cb;
    logic [1:0]   cop;
    logic         ccin, csat;
    logic         vld, rdy;
    int           sent, got, cyc, extra;
    sent = 0; got = 0; cyc = 0; prev_hold = 1'b0; prev = '0;
    ca = W'($urandom); cb = W'($urandom); cop = 2'($urandom); ccin = 1'($urandom); csat = 1'($urandom);
    while (got < n_ops && cyc < 5000) begin
      @(negedge clk);
      if (prev_hold) check("hold_outputs", {bus.out_valid, observed()}, {1'b1, prev});
      if (stall_mode) begin
        vld = (sent < n_ops);
        rdy = !(cyc >= 5 && cyc <= 7);
      end else begin
        vld = (sent < n_ops) && ($urandom_range(0, 3) != 0);
        rdy = ($urandom_range(0, 3) != 0);
      end
      drive(vld, ca, cb, cop, ccin, csat, rdy);
      #1;
      if (stall_mode && cyc >= 5 && cyc <= 7) check("stall_in_ready", bus.in_ready, 1'b0);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", 1'b1, 1'b0);
        else check("stream_result", observed(), exp_q.pop_front());
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
`ifdef CLA_ADDSUB_SAT_EN
        exp_q.push_back(model(ca, cb, cop, ccin, csat));
`else
        exp_q.push_back(model(ca, cb, cop, ccin, 1'b0));
`endif
        sent++;
        ca = W'($urandom); cb = W'($urandom); cop = 2'($urandom); ccin = 1'($urandom); csat = 1'($urandom);
        if ($urandom_range(0, 7) == 0) ca = {1'b0, {(W-1){1'b1}}};
        if ($urandom_range(0, 7) == 0) cb = '1;
      end
      prev_hold = bus.out_valid && !bus.out_ready;
      prev = observed();
      cyc++;
    end
    check("stream_count", got, n_ops);
    @(negedge clk);
    drive(1'b0, '0, '0, OP_ADD, 1'b0, 1'b0, 1'b1);
    extra = 0;
    for (int i = 0; i < LAT + 2; i++) begin
      @(negedge clk);
      if (bus.out_valid) extra++;
    end
    check("stream_no_dup", extra, 0);
  endtask

  initial begin
    int stale;
    drive(1'b0, '0, '0, OP_ADD, 1'b0, 1'b0, 1'b1);
    #1;
    check("reset_out_valid", bus.out_valid, 1'b0);
    check("reset_sum", bus.sum, '0);
    check("reset_flags", {bus.flag_c, bus.flag_v, bus.flag_z, bus.flag_n}, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    directed("sub_neg1",   16'h0000, 16'h0001, OP_SUB, 1'b0, 1'b0, 16'hFFFF, 4'b0001);
    directed("sub_equal",  16'h1234, 16'h1234, OP_SUB, 1'b0, 1'b0, 16'h0000, 4'b1010);
    directed("adc_chain",  16'hFFFF, 16'h0000, OP_ADC, 1'b1, 1'b0, 16'h0000, 4'b1010);
    directed("sbc_borrow", 16'h0005, 16'h0003, OP_SBC, 1'b0, 1'b0, 16'h0001, 4'b1000);
`ifdef CLA_ADDSUB_SAT_EN
    directed("sat_pos",    16'h7FFF, 16'h0001, OP_ADD, 1'b0, 1'b1, 16'h7FFF, 4'b0100);
    directed("sat_neg",    16'h8000, 16'h0001, OP_SUB, 1'b0, 1'b1, 16'h8000, 4'b1101);
`endif
    directed("add_ovf",    16'h7FFF, 16'h0001, OP_ADD, 1'b0, 1'b0, 16'h8000, 4'b0101);

    // Reset with three ops in flight: outputs clear at once, nothing stale appears later.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, W'(16'h1111 * (i + 1)), 16'h0101, OP_ADD, 1'b0, 1'b0, 1'b1);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", bus.out_valid, 1'b0);
    check("midreset_sum", bus.sum, '0);
    check("midreset_flags", {bus.flag_c, bus.flag_v, bus.flag_z, bus.flag_n}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < LAT + 3; i++) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    check("midreset_no_stale", stale, 0);

    stream(8, 1'b1);
    stream(300, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
